amci_cmd_sequencer: RTL

Command sequencer that sits directly upstream of the AMCI-driven AXI4-Lite master and drives its AMCI port. It accepts single read/write commands on a valid/ready stream, converts each into an AMCI one-cycle request pulse, waits for the master to report idle, and returns one response per command on a valid/ready stream. A per-command timeout guards against a hung slave, and running completion counters support bring-up.

---
 rtl/amci_pkg.sv | 31 +++
 rtl/amci_cmd_sequencer_if.sv | 37 +++
 rtl/amci_timeout_counter.sv | 39 +++
 rtl/amci_cmd_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/amci_pkg.sv
// Shared definitions for the AMCI command sequencer: AMCI bus layout,
// command opcodes and the sequencer state encoding.
package amci_pkg;

    localparam int AMCI_MOSI_W    = 98;
    localparam int AMCI_MISO_W    = 34;
    localparam int AMCI_ADDR_W    = 32;
    localparam int AMCI_DATA_W    = 32;

    localparam int MOSI_WADDR_LSB = 0;
    localparam int MOSI_WDATA_LSB = 32;
    localparam int MOSI_RADDR_LSB = 64;
    localparam int MOSI_WRITE_BIT = 96;
    localparam int MOSI_READ_BIT  = 97;

    localparam int MISO_RDATA_LSB = 0;
    localparam int MISO_WIDLE_BIT = 32;
    localparam int MISO_RIDLE_BIT = 33;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        RESPOND = 3'd3,
        HALT    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/amci_cmd_sequencer_if.sv
// Command/response streams, AMCI port and status signals of the sequencer.
interface amci_cmd_sequencer_if #(
    parameter int CNT_WIDTH = 32
) ();

    logic                             CMD_VALID;
    logic                             CMD_READY;
    logic                             CMD_OP;
    logic [amci_pkg::AMCI_ADDR_W-1:0] CMD_ADDR;
    logic [amci_pkg::AMCI_DATA_W-1:0] CMD_DATA;

    logic                             RSP_VALID;
    logic                             RSP_READY;
    logic                             RSP_OP;
    logic [amci_pkg::AMCI_DATA_W-1:0] RSP_DATA;
    logic                             RSP_TIMEOUT;

    logic [amci_pkg::AMCI_MOSI_W-1:0] AMCI_MOSI;
    logic [amci_pkg::AMCI_MISO_W-1:0] AMCI_MISO;

    logic [CNT_WIDTH-1:0]             WR_COUNT;
    logic [CNT_WIDTH-1:0]             RD_COUNT;
    logic                             HALTED;

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, RSP_READY, AMCI_MISO,
        output CMD_READY, RSP_VALID, RSP_OP, RSP_DATA, RSP_TIMEOUT,
               AMCI_MOSI, WR_COUNT, RD_COUNT, HALTED
    );

    modport master (
        output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA, RSP_READY, AMCI_MISO,
        input  CMD_READY, RSP_VALID, RSP_OP, RSP_DATA, RSP_TIMEOUT,
               AMCI_MOSI, WR_COUNT, RD_COUNT, HALTED
    );

endinterface

// File: rtl/amci_timeout_counter.sv
// Per-command WAIT cycle counter; tc_o flags the last allowed WAIT cycle.
module amci_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int             CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LIMIT);

endmodule

// File: rtl/amci_cmd_sequencer.sv
// Turns single read/write commands into AMCI request pulses, waits for the
// master to go idle (or time out) and returns one response per command.
module amci_cmd_sequencer
    import amci_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    amci_cmd_sequencer_if.slave  bus
);

    seq_state_e                 state_q, state_d;
    logic                       op_q, op_d;
    logic                       cmd_ready_q, cmd_ready_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic                       rsp_op_q, rsp_op_d;
    logic [AMCI_DATA_W-1:0]     rsp_data_q, rsp_data_d;
    logic                       rsp_timeout_q, rsp_timeout_d;
    logic [AMCI_MOSI_W-1:0]     mosi_q, mosi_d;
    logic [CNT_WIDTH-1:0]       wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0]       rd_count_q, rd_count_d;
    logic                       halted_q, halted_d;

    logic                       accept_s;
    logic                       idle_s;
    logic                       tmo_clear_s;
    logic                       tmo_enable_s;
    logic                       tmo_tc_s;

    amci_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (ACLK),
        .rst      (ARESET),
        .clear_i  (tmo_clear_s),
        .enable_i (tmo_enable_s),
        .tc_o     (tmo_tc_s)
    );

    assign accept_s = (state_q == IDLE) && cmd_ready_q && bus.CMD_VALID;
    assign idle_s   = (op_q == OP_READ) ? bus.AMCI_MISO[MISO_RIDLE_BIT]
                                        : bus.AMCI_MISO[MISO_WIDLE_BIT];

    // Next-state and next-output logic; the request bits default low so they pulse only in ISSUE.
    always_comb begin
        state_d                 = state_q;
        op_d                    = op_q;
        rsp_valid_d             = rsp_valid_q;
        rsp_op_d                = rsp_op_q;
        rsp_data_d              = rsp_data_q;
        rsp_timeout_d           = rsp_timeout_q;
        mosi_d                  = mosi_q;
        mosi_d[MOSI_WRITE_BIT]  = 1'b0;
        mosi_d[MOSI_READ_BIT]   = 1'b0;
        wr_count_d              = wr_count_q;
        rd_count_d              = rd_count_q;
        halted_d                = halted_q;
        tmo_clear_s             = 1'b0;
        tmo_enable_s            = 1'b0;
        // The one-cycle bubble after a response comes from keying ready on the current state.
        cmd_ready_d             = (state_q == IDLE) && !accept_s;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d = bus.CMD_OP;
                    if (bus.CMD_OP == OP_READ) begin
                        mosi_d[MOSI_RADDR_LSB +: AMCI_ADDR_W] = bus.CMD_ADDR;
                        mosi_d[MOSI_READ_BIT]                 = 1'b1;
                    end else begin
                        mosi_d[MOSI_WADDR_LSB +: AMCI_ADDR_W] = bus.CMD_ADDR;
                        mosi_d[MOSI_WDATA_LSB +: AMCI_DATA_W] = bus.CMD_DATA;
                        mosi_d[MOSI_WRITE_BIT]                = 1'b1;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                tmo_clear_s = 1'b1;
                state_d     = WAIT;
            end
            WAIT: begin
                // Idle is checked before the terminal count so a late success still wins.
                if (idle_s) begin
                    rsp_valid_d   = 1'b1;
                    rsp_op_d      = op_q;
                    rsp_timeout_d = 1'b0;
                    if (op_q == OP_READ) begin
                        rsp_data_d = bus.AMCI_MISO[MISO_RDATA_LSB +: AMCI_DATA_W];
                        rd_count_d = rd_count_q + CNT_WIDTH'(1);
                    end else begin
                        rsp_data_d = {AMCI_DATA_W{1'b0}};
                        wr_count_d = wr_count_q + CNT_WIDTH'(1);
                    end
                    state_d = RESPOND;
                end else if (tmo_tc_s) begin
                    rsp_valid_d   = 1'b1;
                    rsp_op_d      = op_q;
                    rsp_timeout_d = 1'b1;
                    rsp_data_d    = {AMCI_DATA_W{1'b0}};
                    state_d       = RESPOND;
                end else begin
                    tmo_enable_s = 1'b1;
                    state_d      = WAIT;
                end
            end
            RESPOND: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_timeout_q) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    state_d = RESPOND;
                end
            end
            HALT: begin
                halted_d = 1'b1;
                state_d  = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= IDLE;
            op_q          <= OP_WRITE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_op_q      <= 1'b0;
            rsp_data_q    <= {AMCI_DATA_W{1'b0}};
            rsp_timeout_q <= 1'b0;
            mosi_q        <= {AMCI_MOSI_W{1'b0}};
            wr_count_q    <= {CNT_WIDTH{1'b0}};
            rd_count_q    <= {CNT_WIDTH{1'b0}};
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_op_q      <= rsp_op_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            mosi_q        <= mosi_d;
            wr_count_q    <= wr_count_d;
            rd_count_q    <= rd_count_d;
            halted_q      <= halted_d;
        end
    end

    assign bus.CMD_READY   = cmd_ready_q;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_OP      = rsp_op_q;
    assign bus.RSP_DATA    = rsp_data_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;
    assign bus.AMCI_MOSI   = mosi_q;
    assign bus.WR_COUNT    = wr_count_q;
    assign bus.RD_COUNT    = rd_count_q;
    assign bus.HALTED      = halted_q;

endmodule
